// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants and FSM state encoding used by
// alu_logic and its sibling ALU blocks.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_ROL = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } alu_state_e;

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift/rotate of the working register; op[1:0] follows the low bits
// of the shift op-codes (00 SHL, 01 SHR, 10 ROL, 11 ROR).
module alu_shift_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] w,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] w_next
);

    // Select the single-bit move for the requested direction
    always_comb begin
        w_next = w;
        case (op)
            2'b00:   w_next = {w[WIDTH-2:0], 1'b0};
            2'b01:   w_next = {1'b0, w[WIDTH-1:1]};
            2'b10:   w_next = {w[WIDTH-2:0], w[WIDTH-1]};
            2'b11:   w_next = {w[0], w[WIDTH-1:1]};
            default: w_next = w;
        endcase
    end

endmodule

// File: rtl/alu_logic.sv
// Multi-cycle logic/shift ALU: bitwise ops finish in one cycle, shifts and
// rotates walk one bit per cycle through alu_shift_step.
module alu_logic
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] res,
    output logic               done,
    output logic               busy
);

    localparam int SW = $clog2(WIDTH);

    alu_state_e          state_r, state_nxt_s;
    logic [2:0]          op_r, op_nxt_s;
    logic [WIDTH-1:0]    a_r, a_nxt_s;
    logic [WIDTH-1:0]    b_r, b_nxt_s;
    logic [WIDTH-1:0]    w_r, w_nxt_s, w_step_s;
    logic [SW-1:0]       cnt_r, cnt_nxt_s;
    logic [2*WIDTH-1:0]  res_r, res_nxt_s;
    logic                done_r, done_nxt_s;
    logic                busy_r, busy_nxt_s;

    function automatic logic [WIDTH-1:0] bitwise_op(
        input logic [2:0]       opc,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        case (opc)
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_NOT:  return ~x;
            default: return {WIDTH{1'b0}};
        endcase
    endfunction

    alu_shift_step #(.WIDTH(WIDTH)) u_step (
        .w      (w_r),
        .op     (op_r[1:0]),
        .w_next (w_step_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-datapath decode; every field holds unless touched
    always_comb begin
        state_nxt_s = state_r;
        op_nxt_s    = op_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        w_nxt_s     = w_r;
        cnt_nxt_s   = cnt_r;
        res_nxt_s   = res_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    op_nxt_s    = op;
                    a_nxt_s     = a;
                    b_nxt_s     = b;
                    w_nxt_s     = a;
                    cnt_nxt_s   = b[SW-1:0];
                    state_nxt_s = op[2] ? ST_SHIFT : ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                res_nxt_s   = {{WIDTH{1'b0}}, bitwise_op(op_r, a_r, b_r)};
                done_nxt_s  = 1'b1;
                state_nxt_s = ST_DONE;
            end
            ST_SHIFT: begin
                if (cnt_r != {SW{1'b0}}) begin
                    w_nxt_s   = w_step_s;
                    cnt_nxt_s = cnt_r - SW'(1);
                end else begin
                    res_nxt_s   = {{WIDTH{1'b0}}, w_r};
                    done_nxt_s  = 1'b1;
                    state_nxt_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // Operand, working and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r   <= 3'b000;
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            w_r    <= {WIDTH{1'b0}};
            cnt_r  <= {SW{1'b0}};
            res_r  <= {(2*WIDTH){1'b0}};
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            op_r   <= op_nxt_s;
            a_r    <= a_nxt_s;
            b_r    <= b_nxt_s;
            w_r    <= w_nxt_s;
            cnt_r  <= cnt_nxt_s;
            res_r  <= res_nxt_s;
            done_r <= done_nxt_s;
            busy_r <= busy_nxt_s;
        end
    end

    assign res  = res_r;
    assign done = done_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_alu_logic.sv
// Directed self-checking bench for alu_logic at WIDTH=8 and WIDTH=16.
module tb_alu_logic;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  a, b;
    logic [15:0] res;
    logic        done, busy;

    logic        start16;
    logic [2:0]  op16;
    logic [15:0] a16, b16;
    logic [31:0] res16;
    logic        done16, busy16;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int pulses_cnt = 0;

    always #5 clk = ~clk;

    alu_logic #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .res(res), .done(done), .busy(busy)
    );

    alu_logic #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
        .res(res16), .done(done16), .busy(busy16)
    );

    // Count cycles in which the 8-bit done output was high
    always @(posedge clk) begin
        if (done === 1'b1) pulses_cnt <= pulses_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one 8-bit request, measure latency in edges, check result and pulse
    task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [15:0] exp_res,
                        input int exp_lat, input bit toggle);
        int n;
        int p0;
        p0 = pulses_cnt;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        if (!toggle) start = 1'b0;
        check({tag, "_busy_k"}, 64'(busy), 64'(1));
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (toggle) begin
                start = ~start;
                a = 8'($urandom);
                b = 8'($urandom);
                op = 3'($urandom);
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_res"}, 64'(res), 64'(exp_res));
        check({tag, "_busy_done"}, 64'(busy), 64'(1));
        @(negedge clk);
        check({tag, "_done_clr"}, 64'(done), 64'(0));
        check({tag, "_idle"}, 64'(busy), 64'(0));
        @(negedge clk);
        @(negedge clk);
        check({tag, "_hold"}, 64'(res), 64'(exp_res));
        check({tag, "_pulses"}, 64'(pulses_cnt - p0), 64'(1));
    endtask

    task automatic run16(input string tag, input logic [2:0] o, input logic [15:0] x,
                         input logic [15:0] y, input logic [31:0] exp_res);
        int n;
        @(negedge clk);
        start16 = 1'b1; op16 = o; a16 = x; b16 = y;
        @(negedge clk);
        start16 = 1'b0;
        n = 0;
        while (done16 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(1));
        check({tag, "_res"}, 64'(res16), 64'(exp_res));
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int p0;
        reset = 1'b1; start = 1'b1; op = 3'b000; a = 8'hFF; b = 8'hFF;
        start16 = 1'b0; op16 = 3'b000; a16 = 16'h0000; b16 = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_res", 64'(res), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'(0));

        run8("and",      3'b000, 8'hC3, 8'h5A, 16'h0042, 1, 1'b0);
        run8("rol3",     3'b110, 8'h81, 8'h03, 16'h000C, 4, 1'b0);
        run8("shr0",     3'b101, 8'h80, 8'hF8, 16'h0080, 1, 1'b0);
        run8("shl7_tgl", 3'b100, 8'h01, 8'h07, 16'h0080, 8, 1'b1);
        run8("or",       3'b001, 8'hA0, 8'h05, 16'h00A5, 1, 1'b0);
        run8("xor",      3'b010, 8'hF0, 8'h3C, 16'h00CC, 1, 1'b0);
        run8("not",      3'b011, 8'h3C, 8'h00, 16'h00C3, 1, 1'b0);
        run8("shr3",     3'b101, 8'h80, 8'h03, 16'h0010, 4, 1'b0);
        run8("ror1",     3'b111, 8'h01, 8'h01, 16'h0080, 2, 1'b0);
        run8("shl4",     3'b100, 8'hFF, 8'h04, 16'h00F0, 5, 1'b0);

        // Abort a rotate with reset at edge k+2
        p0 = pulses_cnt;
        @(negedge clk);
        start = 1'b1; op = 3'b111; a = 8'h55; b = 8'h05;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_res", 64'(res), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        repeat (8) @(negedge clk);
        check("abort_pulses", 64'(pulses_cnt - p0), 64'(0));
        run8("and_after", 3'b000, 8'hFF, 8'h0F, 16'h000F, 1, 1'b0);

        run16("xor16", 3'b010, 16'hFFFF, 16'h1234, 32'h0000EDCB);
        run16("not16", 3'b011, 16'h00FF, 16'h0000, 32'h0000FF00);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/alu_logic.md
ALU_LOGIC -- requirements
Module: alu_logic

Interface
REQ-001 Parameter WIDTH, default 8, operand width; SHALL be a power of two, 2..64.
REQ-002 Parameter SW, default $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  3  operation: 000 AND, 001 OR, 010 XOR, 011 NOT a, 100 SHL, 101 SHR (logical), 110 ROL, 111 ROR.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B for ops 000-010; b[SW-1:0] is the shift amount for ops 100-111, upper bits ignored.
REQ-009 res  output  2*WIDTH  registered result, zero-extended.
REQ-010 done  output  1  registered one-cycle completion pulse.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 States SHALL be IDLE, CALC, SHIFT, DONE.
REQ-013 IDLE with start=1 at edge k: a, b, op captured into internal registers; next state CALC for ops 000-011, SHIFT for ops 100-111; else stay IDLE.
REQ-014 Inputs a, b, op SHALL be ignored after the capture edge until the next accepted start.
REQ-015 CALC: at edge k+1 res <= {WIDTH zeros, A op B}, done <= 1, next state DONE.
REQ-016 SHIFT: capture edge loads working reg W <= a and counter cnt <= b[SW-1:0].
REQ-017 SHIFT with cnt != 0: each edge shifts/rotates W by one bit in the op's direction, cnt <= cnt-1; SHL/SHR fill with 0.
REQ-018 SHIFT with cnt == 0: res <= {WIDTH zeros, W}, done <= 1, next state DONE; latency from capture edge SHALL be n+1 edges for shift amount n.
REQ-019 Shift amount 0 SHALL return a unchanged at edge k+1.
REQ-020 DONE: done <= 0, next state IDLE; start in DONE SHALL be ignored, so the earliest next accept is 3 edges after a bitwise capture.
REQ-021 start while busy SHALL be ignored, with no effect on operands, res or timing.
REQ-022 res SHALL hold its value between completions; done SHALL be high for exactly one cycle per accepted start.
REQ-023 Upper WIDTH bits of res SHALL always be 0.

Reset
REQ-024 reset=1 at any edge SHALL force state IDLE, res=0, done=0, busy=0, and internal A, B, W, cnt to 0; reset takes priority over start.
REQ-025 Reset mid-operation SHALL abort with no done pulse; the first start after reset deasserts SHALL be accepted normally.

Structure
REQ-026 Package alu_pkg SHALL hold the op-code constants and the state encoding; both are shared with the sibling ALU blocks.
REQ-027 Sub-module alu_shift_step SHALL be a combinational one-bit shift/rotate, parametrised by WIDTH, with inputs W and op[1:0], and output the next W.
REQ-028 The FSM, counter and registers SHALL reside in alu_logic; there SHALL be no multiplier or barrel shifter.

Verification
REQ-029 WIDTH=8, op=000, a=0xC3, b=0x5A, start at edge k -> res=0x0042, done high only after edge k+1.
REQ-030 WIDTH=8, op=110, a=0x81, b=0x03 -> res=0x000C, done after edge k+4, busy high edges k..k+5.
REQ-031 WIDTH=8, op=101, a=0x80, b=0xF8 (shift amount 0) -> res=0x0080 after edge k+1.
REQ-032 op=100, a=0x01, b=0x07, start and a/b toggled every cycle while busy -> res=0x0080 after edge k+8, one done pulse only.
REQ-033 op=111, b=0x05, reset at edge k+2 -> no done pulse, res=0x0000, busy=0; a new AND request then completes normally.
REQ-034 WIDTH=16, op=010, a=0xFFFF, b=0x1234 -> res=0x0000EDCB; op=011, a=0x00FF -> res=0x0000FF00.
